// File: rtl/regfile_write_arbiter.sv
// Two-requester (ALU / load) arbiter for the register file's single write port, with a registered output stage.
// Optional per-side grant and conflict counters are enabled with the WRARB_STATS_EN macro.
module regfile_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIXED_PRIO = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              AValid,
    output logic              AReady,
    input  logic [ADDR_W-1:0] AReg,
    input  logic [DATA_W-1:0] AData,
    input  logic              MValid,
    output logic              MReady,
    input  logic [ADDR_W-1:0] MReg,
    input  logic [DATA_W-1:0] MData,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
`ifdef WRARB_STATS_EN
    output logic              Idle,
    output logic [15:0]       GrantCntA,
    output logic [15:0]       GrantCntM,
    output logic [15:0]       ConflictCnt
`else
    output logic              Idle
`endif
);

    // Round-robin turn: 0 = A wins the next conflict, 1 = M wins it.
    logic              prio;
    logic              acceptA_p0;
    logic              acceptM_p0;
    logic              accept_p0;
    logic [ADDR_W-1:0] selReg_p0;
    logic [DATA_W-1:0] selData_p0;

    logic              vld_p1;
    logic [ADDR_W-1:0] writeReg_p1;
    logic [DATA_W-1:0] writeData_p1;

    always_comb begin
        AReady = 1'b0;
        MReady = 1'b0;
        if (!Reset && !Stall) begin
            if (AValid && MValid) begin
                if (FIXED_PRIO != 0 || prio) begin
                    MReady = 1'b1;
                end else begin
                    AReady = 1'b1;
                end
            end else if (AValid) begin
                AReady = 1'b1;
            end else if (MValid) begin
                MReady = 1'b1;
            end
        end
    end

    assign acceptA_p0 = AValid && AReady;
    assign acceptM_p0 = MValid && MReady;
    assign accept_p0  = acceptA_p0 || acceptM_p0;
    assign selReg_p0  = acceptM_p0 ? MReg  : AReg;
    assign selData_p0 = acceptM_p0 ? MData : AData;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prio <= 1'b0;
        end else if (FIXED_PRIO == 0 && accept_p0) begin
            prio <= acceptA_p0;
        end
    end

    // ---- stage p0 -> p1: registered write port ----
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vld_p1       <= 1'b0;
            writeReg_p1  <= '0;
            writeData_p1 <= '0;
        end else if (accept_p0) begin
            vld_p1       <= (selReg_p0 != '0);
            writeReg_p1  <= selReg_p0;
            writeData_p1 <= selData_p0;
        end else begin
            vld_p1       <= 1'b0;
        end
    end

    assign RegWrite      = vld_p1;
    assign WriteRegister = writeReg_p1;
    assign WriteData     = writeData_p1;
    assign Idle          = Reset || (!AValid && !MValid && !vld_p1);

`ifdef WRARB_STATS_EN
    function automatic logic [15:0] satInc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            GrantCntA   <= '0;
            GrantCntM   <= '0;
            ConflictCnt <= '0;
        end else begin
            if (acceptA_p0) GrantCntA <= satInc(GrantCntA);
            if (acceptM_p0) GrantCntM <= satInc(GrantCntM);
            if (AValid && MValid && !Stall) ConflictCnt <= satInc(ConflictCnt);
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench: round-robin and fixed-priority arbiters share one stimulus stream
// and are compared against a cycle-level reference model.
module tb_regfile_write_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        AValid, MValid;
    logic [4:0]  AReg, MReg;
    logic [31:0] AData, MData;

    logic        aReady[2], mReady[2], regWrite[2], idle[2];
    logic [4:0]  writeRegister[2];
    logic [31:0] writeData[2];
`ifdef WRARB_STATS_EN
    logic [15:0] grantCntA[2], grantCntM[2], conflictCnt[2];
`endif

    always #5 Clk = ~Clk;

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRIO(0)) dutRr (
        .Clk(Clk), .Reset(Reset), .Stall(Stall),
        .AValid(AValid), .AReady(aReady[0]), .AReg(AReg), .AData(AData),
        .MValid(MValid), .MReady(mReady[0]), .MReg(MReg), .MData(MData),
        .RegWrite(regWrite[0]), .WriteRegister(writeRegister[0]), .WriteData(writeData[0]),
`ifdef WRARB_STATS_EN
        .GrantCntA(grantCntA[0]), .GrantCntM(grantCntM[0]), .ConflictCnt(conflictCnt[0]),
`endif
        .Idle(idle[0])
    );

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRIO(1)) dutFix (
        .Clk(Clk), .Reset(Reset), .Stall(Stall),
        .AValid(AValid), .AReady(aReady[1]), .AReg(AReg), .AData(AData),
        .MValid(MValid), .MReady(mReady[1]), .MReg(MReg), .MData(MData),
        .RegWrite(regWrite[1]), .WriteRegister(writeRegister[1]), .WriteData(writeData[1]),
`ifdef WRARB_STATS_EN
        .GrantCntA(grantCntA[1]), .GrantCntM(grantCntM[1]), .ConflictCnt(conflictCnt[1]),
`endif
        .Idle(idle[1])
    );

    int nChecks = 0;
    int nPass   = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model. lastWin: side that won the most recent transfer (1 = A, 2 = M).
    int          lastWin[2];
    int          lastGrant[2];
    logic        expRW[2];
    logic [4:0]  expWR[2];
    logic [31:0] expWD[2];
    int          expCntA[2], expCntM[2], expCntC[2];

    // 0 = no grant, 1 = A, 2 = M
    function automatic int grantOf(int d);
        if (Reset || Stall) return 0;
        if (AValid && !MValid) return 1;
        if (MValid && !AValid) return 2;
        if (!AValid && !MValid) return 0;
        if (d == 1) return 2;
        return (lastWin[d] == 1) ? 2 : 1;
    endfunction

    function automatic int sat16(int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            lastWin[d] = 2;
            expRW[d] = 1'b0; expWR[d] = '0; expWD[d] = '0;
            expCntA[d] = 0; expCntM[d] = 0; expCntC[d] = 0;
        end
    endtask

    task automatic checkOutputs();
        for (int d = 0; d < 2; d++) begin
            string p;
            p = (d == 0) ? "rr" : "fix";
            checkVal({p, ".RegWrite"},      regWrite[d],      expRW[d]);
            checkVal({p, ".WriteRegister"}, writeRegister[d], expWR[d]);
            checkVal({p, ".WriteData"},     writeData[d],     expWD[d]);
            checkVal({p, ".Idle"}, idle[d], Reset || (!AValid && !MValid && !expRW[d]));
`ifdef WRARB_STATS_EN
            checkVal({p, ".GrantCntA"},   grantCntA[d],   expCntA[d]);
            checkVal({p, ".GrantCntM"},   grantCntM[d],   expCntM[d]);
            checkVal({p, ".ConflictCnt"}, conflictCnt[d], expCntC[d]);
`endif
        end
    endtask

    // One clock: check Ready before the edge, advance the model on the edge, check outputs after it.
    task automatic cycle();
        int g[2];
        #1;
        for (int d = 0; d < 2; d++) begin
            g[d] = grantOf(d);
            checkVal((d == 0) ? "rr.AReady" : "fix.AReady", aReady[d], g[d] == 1);
            checkVal((d == 0) ? "rr.MReady" : "fix.MReady", mReady[d], g[d] == 2);
        end
        @(posedge Clk);
        for (int d = 0; d < 2; d++) begin
            lastGrant[d] = g[d];
            if (g[d] != 0) begin
                expWR[d] = (g[d] == 1) ? AReg : MReg;
                expWD[d] = (g[d] == 1) ? AData : MData;
                expRW[d] = (expWR[d] != 0);
                lastWin[d] = g[d];
                if (g[d] == 1) expCntA[d] = sat16(expCntA[d]);
                else           expCntM[d] = sat16(expCntM[d]);
            end else begin
                expRW[d] = 1'b0;
            end
            if (!Reset && !Stall && AValid && MValid) expCntC[d] = sat16(expCntC[d]);
        end
        #1;
        checkOutputs();
    endtask

    task automatic setIn(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md);
        AValid = av; AReg = ar; AData = ad;
        MValid = mv; MReg = mr; MData = md;
    endtask

    initial begin
        Reset = 1'b1; Stall = 1'b0;
        setIn(0, 0, 0, 0, 0, 0);
        modelReset();
        cycle();
        cycle();
        Reset = 1'b0;
        cycle();

        // Single ALU write
        setIn(1, 5, 32'hDEADBEEF, 0, 0, 0);
        cycle();
        checkVal("first.WriteData", writeData[0], 64'hDEADBEEF);
        setIn(0, 0, 0, 0, 0, 0);
        cycle();

        // Sustained conflict: rr alternates A/M, fixed always M
        setIn(1, 8, 32'h8888, 1, 9, 32'h9999);
        for (int i = 0; i < 4; i++) cycle();
        setIn(1, 8, 32'h8888, 0, 0, 0);
        cycle();
        checkVal("fix.ADropM", writeRegister[1], 64'd8);
        setIn(0, 0, 0, 0, 0, 0);
        cycle();

        // Register 0 accepted but not written
        setIn(1, 0, 32'h1234, 0, 0, 0);
        cycle();
        checkVal("reg0.RegWrite", regWrite[0], 64'd0);
        setIn(0, 0, 0, 0, 0, 0);
        cycle();

        // Stall with both valid, entered while a write is in the output stage
        setIn(0, 0, 0, 1, 3, 32'h3333);
        cycle();
        setIn(1, 4, 32'h4444, 1, 6, 32'h6666);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        Stall = 1'b0;
        cycle();
        cycle();
        setIn(0, 0, 0, 0, 0, 0);

        // Reset while a write sits in the output stage
        setIn(0, 0, 0, 1, 7, 32'h7777);
        cycle();
        Reset = 1'b1;
        #1;
        modelReset();
        checkOutputs();
        checkVal("rst.AReady", aReady[0], 64'd0);
        checkVal("rst.MReady", mReady[0], 64'd0);
        cycle();
        Reset = 1'b0;
        setIn(1, 10, 32'hAAAA, 1, 11, 32'hBBBB);
        cycle();
        checkVal("postRst.rrFirst", writeRegister[0], 64'd10);
        cycle();

        // Random traffic obeying hold-until-accepted on the round-robin arbiter
        for (int i = 0; i < 400; i++) begin
            if (!AValid || lastGrant[0] == 1) begin
                AValid = ($urandom_range(0, 3) != 0);
                AReg   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                AData  = $urandom;
            end
            if (!MValid || lastGrant[0] == 2) begin
                MValid = ($urandom_range(0, 3) != 0);
                MReg   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                MData  = $urandom;
            end
            Stall = ($urandom_range(0, 4) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
